muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; the multi-cycle companion to the single-cycle integer ALU in the execute stage.
- Accepts one operation at a time through a start/ready handshake and produces the result after a fixed, data-independent iteration count.
- The divide-by-zero and signed-overflow corner cases complete early.
- Hazard logic stalls the pipeline while Ready_o is low.

Parameters:
DATA_WIDTH, 32, operand/result width; must be even and >= 8.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  synchronous active-low reset
Start_i  input  1  request; accepted only when Ready_o=1
MulDivOp_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA_i  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
SrcB_i  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
Flush_i  input  1  abort the in-flight operation
Ready_o  output  1  unit can accept Start_i this cycle
Done_o  output  1  one-cycle pulse; Result_o valid
Result_o  output  DATA_WIDTH  result; held until the next Done_o

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_n_i is synchronous and active-low.
- Reset values: state=IDLE, Done_o=0, Result_o=0, iteration counter=0. Ready_o=1 once out of reset.
- Reset asserted mid-operation discards the operation. No Done_o is produced.

States:
- IDLE: Ready_o=1.
- CALC: Ready_o=0.
- DONE: Ready_o=1, Done_o=1.

Accepting an operation:
- Acceptance requires Start_i=1, Ready_o=1 and Flush_i=0, sampled on rising edge E0.
- On acceptance: latch the operation; latch the absolute values of the operands (absolute value for signed ops only); latch the result-sign flags.
- MULHSU treats SrcA_i as signed and SrcB_i as unsigned.

Early path:
- Applies to div/rem ops when divisor==0, or for signed DIV/REM when SrcA=most-negative and SrcB=all-ones.
- Goes straight to DONE at E0; Done_o is high in the cycle after E0 (latency 1).
- Divisor==0: DIV/DIVU give all-ones; REM/REMU give SrcA_i.
- Signed overflow: DIV gives most-negative; REM gives 0.

Normal path:
- Enter CALC at E0. Perform exactly DATA_WIDTH iterations, one per cycle, with the counter running 0..DATA_WIDTH-1.
- Enter DONE on edge E0+DATA_WIDTH; Done_o is high in the cycle following that edge.
- Multiply: radix-2 shift-add into a 2*DATA_WIDTH accumulator. Negate the product (two's complement, full 2W) if the result-sign flag is set.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half.
- Divide: restoring shift-subtract on the unsigned magnitudes.
  - Quotient is negated if operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- All arithmetic wraps modulo 2^DATA_WIDTH; there is no saturation.

DONE state:
- Lasts exactly one cycle. Result_o is registered on the DONE-entry edge.
- Next state is IDLE, or CALC/DONE if a new Start_i is accepted in the DONE cycle. This gives back-to-back issue with no bubble.

Start_i and Flush_i rules:
- Start_i while in CALC is ignored; no queueing.
- Flush_i=1 in any state returns the unit to IDLE on the next edge.
  - Suppresses a pending Done_o transition.
  - Blocks acceptance of a same-cycle Start_i.
  - Leaves Result_o unchanged.
- Flush_i in the DONE cycle does not retract the Done_o already high in that cycle.
- Operand inputs are don't-care after acceptance; changing them mid-CALC has no effect.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD (-3): Done_o 33 cycles after accept, Result_o=0xFFFFFFEB; MULHU with SrcA=SrcB=0xFFFFFFFF gives 0xFFFFFFFE.
- MULH, SrcA=SrcB=0x80000000 -> 0x40000000; MULHSU, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU, SrcA=100, SrcB=7 -> 14; REMU -> 2.
- Early paths, all with Done_o one cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush_i pulsed 10 cycles into a DIV: no Done_o ever appears, Ready_o=1 next cycle, Result_o keeps its previous value; a new MUL 3*4 then returns 12.
- Back-to-back: Start_i held high with MUL 2*3 then DIVU 9/3: Done_o at cycles 33 and 66, Results 6 then 3, Ready_o low during each CALC. Separately, rst_n_i=0 mid-CALC: Done_o=0, Result_o=0, Ready_o=1 after release.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. It runs beside the single-cycle ALU in
// the execute stage. It accepts one operation at a time and finishes after a
// fixed DATA_WIDTH iterations. Divide-by-zero and signed overflow (MIN / -1)
// bypass the iterations and finish on the accepting edge.
//
// Ports
//    clk_i       : clock, rising edge
//    rst_n_i     : synchronous active-low reset
//    Start_i     : operation request, taken only while Ready_o=1 and Flush_i=0
//    MulDivOp_i  : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//    SrcA_i      : rs1 (multiplicand / dividend)
//    SrcB_i      : rs2 (multiplier / divisor)
//    Flush_i     : abort whatever is in flight, back to IDLE
//    Ready_o     : unit can accept Start_i this cycle
//    Done_o      : one-cycle pulse, Result_o valid
//    Result_o    : result, held until the next Done_o
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  Start_i,
   input  logic [2:0]            MulDivOp_i,
   input  logic [DATA_WIDTH-1:0] SrcA_i,
   input  logic [DATA_WIDTH-1:0] SrcB_i,
   input  logic                  Flush_i,
   output logic                  Ready_o,
   output logic                  Done_o,
   output logic [DATA_WIDTH-1:0] Result_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_t            r_state;
   logic              r_ready;
   logic              r_done;
   logic [W-1:0]      r_result;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic              r_is_div;
   logic              r_neg;      // negate final product / quotient / remainder
   logic [W-1:0]      r_opa;      // multiplicand (mul) or divisor (div) magnitude
   logic [2*W-1:0]    r_acc;      // mul: {partial hi, multiplier}; div: {rem, quotient}

   // ---------------------------------------------------------------------
   // Operand decode at acceptance
   // ---------------------------------------------------------------------
   logic              w_is_div;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [W-1:0]      w_a_abs;
   logic [W-1:0]      w_b_abs;
   logic              w_neg_flag;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_early;
   logic [W-1:0]      w_early_result;

   always_comb begin
      w_is_div   = MulDivOp_i[2];
      w_a_signed = (MulDivOp_i == OP_MULH) || (MulDivOp_i == OP_MULHSU) ||
                   (MulDivOp_i == OP_DIV)  || (MulDivOp_i == OP_REM);
      w_b_signed = (MulDivOp_i == OP_MULH) || (MulDivOp_i == OP_DIV) ||
                   (MulDivOp_i == OP_REM);
      w_a_neg    = w_a_signed & SrcA_i[W-1];
      w_b_neg    = w_b_signed & SrcB_i[W-1];
      w_a_abs    = w_a_neg ? (-SrcA_i) : SrcA_i;
      w_b_abs    = w_b_neg ? (-SrcB_i) : SrcB_i;
      // Remainder follows the dividend; products and quotients follow the
      // xor of the operand signs (zero for unsigned operands).
      w_neg_flag = (MulDivOp_i == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

      w_div_zero = w_is_div && (SrcB_i == '0);
      w_ovf      = ((MulDivOp_i == OP_DIV) || (MulDivOp_i == OP_REM)) &&
                   (SrcA_i == MOST_NEG) && (SrcB_i == '1);
      w_early    = w_div_zero || w_ovf;

      // funct3[1] separates REM/REMU from DIV/DIVU.
      w_early_result = '0;
      if (w_div_zero) begin
         w_early_result = MulDivOp_i[1] ? SrcA_i : '1;
      end else if (w_ovf) begin
         w_early_result = MulDivOp_i[1] ? '0 : MOST_NEG;
      end
   end

   // ---------------------------------------------------------------------
   // One iteration step
   // ---------------------------------------------------------------------
   logic [W:0]        w_mul_sum;
   logic [2*W-1:0]    w_mul_next;
   logic [W:0]        w_div_shift;
   logic [W:0]        w_div_sub;
   logic              w_div_ge;
   logic [W-1:0]      w_div_rem;
   logic [2*W-1:0]    w_div_next;
   logic [2*W-1:0]    w_acc_step;

   always_comb begin
      // Shift-add: add the multiplicand to the upper half when the current
      // multiplier LSB is set, then shift the whole accumulator (with carry)
      // right by one. The multiplier drains out of the low half.
      w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opa} : '0);
      w_mul_next = {w_mul_sum, r_acc[W-1:1]};

      // Restoring divide: shift the next dividend bit into the partial
      // remainder and subtract when it fits. Since rem < divisor, the shifted
      // value is < 2*divisor and the kept remainder always fits W bits.
      w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
      w_div_sub   = w_div_shift - {1'b0, r_opa};
      w_div_ge    = (w_div_shift >= {1'b0, r_opa});
      w_div_rem   = w_div_ge ? w_div_sub[W-1:0] : w_div_shift[W-1:0];
      w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_ge};

      w_acc_step  = r_is_div ? w_div_next : w_mul_next;
   end

   // ---------------------------------------------------------------------
   // Final result selection, evaluated on the last iteration edge
   // ---------------------------------------------------------------------
   logic [2*W-1:0]    w_prod;
   logic [W-1:0]      w_quo;
   logic [W-1:0]      w_rem;
   logic [W-1:0]      w_final;

   always_comb begin
      w_prod = r_neg ? (-w_acc_step) : w_acc_step;
      w_quo  = r_neg ? (-w_acc_step[W-1:0]) : w_acc_step[W-1:0];
      w_rem  = r_neg ? (-w_acc_step[2*W-1:W]) : w_acc_step[2*W-1:W];
      unique case (r_op)
         OP_MUL:                        w_final = w_prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*W-1:W];
         OP_DIV, OP_DIVU:               w_final = w_quo;
         OP_REM, OP_REMU:               w_final = w_rem;
         default:                       w_final = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state  <= ST_IDLE;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cnt    <= '0;
         r_op     <= OP_MUL;
         r_is_div <= 1'b0;
         r_neg    <= 1'b0;
         r_opa    <= '0;
         r_acc    <= '0;
      end else if (Flush_i) begin
         // Abort: drop any pending completion and refuse a same-cycle start.
         r_state <= ST_IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (Start_i) begin
                  r_op     <= MulDivOp_i;
                  r_is_div <= w_is_div;
                  r_neg    <= w_neg_flag;
                  r_cnt    <= '0;
                  if (w_is_div) begin
                     r_opa <= w_b_abs;
                     r_acc <= {{W{1'b0}}, w_a_abs};
                  end else begin
                     r_opa <= w_a_abs;
                     r_acc <= {{W{1'b0}}, w_b_abs};
                  end
                  if (w_early) begin
                     r_state  <= ST_DONE;
                     r_ready  <= 1'b1;
                     r_done   <= 1'b1;
                     r_result <= w_early_result;
                  end else begin
                     r_state <= ST_CALC;
                     r_ready <= 1'b0;
                     r_done  <= 1'b0;
                  end
               end else begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_CALC: begin
               r_acc <= w_acc_step;
               if (r_cnt == LAST_CNT) begin
                  r_state  <= ST_DONE;
                  r_ready  <= 1'b1;
                  r_done   <= 1'b1;
                  r_result <= w_final;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign Ready_o  = r_ready;
   assign Done_o   = r_done;
   assign Result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit (DATA_WIDTH = 32). Inputs are
// driven on the falling edge, outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic        clk_i;
   logic        rst_n_i;
   logic        Start_i;
   logic [2:0]  MulDivOp_i;
   logic [31:0] SrcA_i;
   logic [31:0] SrcB_i;
   logic        Flush_i;
   logic        Ready_o;
   logic        Done_o;
   logic [31:0] Result_o;

   int n_checks;
   int n_fail;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .Start_i    (Start_i),
      .MulDivOp_i (MulDivOp_i),
      .SrcA_i     (SrcA_i),
      .SrcB_i     (SrcB_i),
      .Flush_i    (Flush_i),
      .Ready_o    (Ready_o),
      .Done_o     (Done_o),
      .Result_o   (Result_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one operation, wait for Done_o (bounded), check latency, result,
   // Ready_o during the calculation and that Done_o is a single-cycle pulse.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      @(negedge clk_i);
      check_val({tag, " ready"}, 32'(Ready_o), 32'd1);
      Start_i    = 1'b1;
      MulDivOp_i = op;
      SrcA_i     = a;
      SrcB_i     = b;
      @(posedge clk_i);
      #1;
      Start_i = 1'b0;
      SrcA_i  = $urandom;   // operands are don't-care after acceptance
      SrcB_i  = $urandom;
      lat = 1;
      if (exp_lat > 1) check_val({tag, " ready_calc"}, 32'(Ready_o), 32'd0);
      while (!Done_o && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, " result"}, Result_o, exp_res);
      @(posedge clk_i);
      #1;
      check_val({tag, " done_pulse"}, 32'(Done_o), 32'd0);
      check_val({tag, " hold"}, Result_o, exp_res);
      $display("op=%0d a=0x%08h b=0x%08h -> 0x%08h lat=%0d (%s)", op, a, b, Result_o, lat, tag);
   endtask

   initial begin
      int dones;
      int first_done;
      int second_done;
      logic [31:0] res_a;
      logic [31:0] res_b;

      n_checks   = 0;
      n_fail     = 0;
      rst_n_i    = 1'b0;
      Start_i    = 1'b0;
      Flush_i    = 1'b0;
      MulDivOp_i = 3'b000;
      SrcA_i     = '0;
      SrcB_i     = '0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check_val("rst done", 32'(Done_o), 32'd0);
      check_val("rst result", Result_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_val("rst ready", 32'(Ready_o), 32'd1);

      // Normal path
      run_op("mul 7*-3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulhu max",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh min*min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhsu -1*max", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("div -7/2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
      run_op("rem -7/2",      OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
      run_op("divu 100/7",    OP_DIVU,   32'd100,      32'd7,        32'd14,        33);
      run_op("remu 100/7",    OP_REMU,   32'd100,      32'd7,        32'd2,         33);

      // Early paths
      run_op("div 5/0",       OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1);
      run_op("remu 5/0",      OP_REMU,   32'd5,        32'd0,        32'd5,         1);
      run_op("div ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Flush 10 cycles into a DIV: no Done_o, Result_o keeps 0 from rem ovf
      @(negedge clk_i);
      Start_i = 1'b1; MulDivOp_i = OP_DIV; SrcA_i = 32'd1000; SrcB_i = 32'd3;
      @(negedge clk_i);
      Start_i = 1'b0;
      repeat (9) @(negedge clk_i);
      Flush_i = 1'b1;
      Start_i = 1'b1;   // same-cycle start must be blocked by the flush
      MulDivOp_i = OP_MUL; SrcA_i = 32'd9; SrcB_i = 32'd9;
      @(posedge clk_i);
      #1;
      Flush_i = 1'b0;
      Start_i = 1'b0;
      check_val("flush ready", 32'(Ready_o), 32'd1);
      check_val("flush result", Result_o, 32'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done_o) dones++;
         @(posedge clk_i);
         #1;
      end
      check_val("flush no_done", 32'(dones), 32'd0);
      check_val("flush idle_ready", 32'(Ready_o), 32'd1);
      $display("flush: dones=%0d result=0x%08h", dones, Result_o);
      run_op("mul 3*4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

      // Back-to-back: Start_i held, MUL 2*3 then DIVU 9/3 taken in the DONE cycle
      @(negedge clk_i);
      Start_i = 1'b1; MulDivOp_i = OP_MUL; SrcA_i = 32'd2; SrcB_i = 32'd3;
      @(posedge clk_i);
      #1;
      MulDivOp_i = OP_DIVU; SrcA_i = 32'd9; SrcB_i = 32'd3;
      dones = 0; first_done = 0; second_done = 0; res_a = '0; res_b = '0;
      for (int lat = 1; lat <= 70; lat++) begin
         if (lat == 2)  check_val("b2b ready_calc1", 32'(Ready_o), 32'd0);
         if (lat == 35) check_val("b2b ready_calc2", 32'(Ready_o), 32'd0);
         if (Done_o) begin
            dones++;
            if (first_done == 0) begin
               first_done = lat; res_a = Result_o;
            end else begin
               second_done = lat; res_b = Result_o;
            end
         end
         if (lat == 34) Start_i = 1'b0;
         @(posedge clk_i);
         #1;
      end
      check_val("b2b count", 32'(dones), 32'd2);
      check_val("b2b first_lat", 32'(first_done), 32'd33);
      check_val("b2b first_res", res_a, 32'd6);
      check_val("b2b second_lat", 32'(second_done), 32'd66);
      check_val("b2b second_res", res_b, 32'd3);
      $display("b2b: done at %0d (0x%08h) and %0d (0x%08h)", first_done, res_a, second_done, res_b);

      // Reset mid-CALC
      @(negedge clk_i);
      Start_i = 1'b1; MulDivOp_i = OP_MUL; SrcA_i = 32'd5; SrcB_i = 32'd5;
      @(negedge clk_i);
      Start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      rst_n_i = 1'b0;
      @(posedge clk_i);
      #1;
      check_val("rstmid done", 32'(Done_o), 32'd0);
      check_val("rstmid result", Result_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_val("rstmid ready", 32'(Ready_o), 32'd1);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (Done_o) dones++;
         @(posedge clk_i);
         #1;
      end
      check_val("rstmid no_done", 32'(dones), 32'd0);
      check_val("rstmid result_hold", Result_o, 32'd0);
      $display("reset mid-calc: dones=%0d result=0x%08h", dones, Result_o);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
